// File: rtl/mem_access_sequencer.sv
// Load/store sequencer: breaks byte/half/word requests into single-byte
// memory cycles (big-endian, MSB first) and sign/zero-extends load data.
module mem_access_sequencer #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int MEM_AW = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              busy,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t              state_q;
    logic                we_q, uns_q;
    logic [1:0]          last_q, cnt_q;   // last_q = N-1
    logic [MEM_AW-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q, acc_q;
    logic                mem_we_q;
    logic [MEM_AW-1:0]   mem_addr_q;
    logic [7:0]          mem_wdata_q;
    logic                resp_valid_q, resp_err_q;
    logic [DATA_W-1:0]   resp_rdata_q;

    logic [1:0]          req_last;
    logic [ADDR_W:0]     req_end;
    logic                req_err;
    logic [1:0]          cnt_d;
    logic [DATA_W-1:0]   acc_d;

    // Byte idx of a right-justified word, byte 0 = bits [7:0]
    function automatic logic [7:0] byte_sel(input logic [DATA_W-1:0] d, input logic [1:0] idx);
        return d[{idx, 3'b000} +: 8];
    endfunction

    // Extend the low N bytes of the accumulator to a full word
    function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] v, input logic [1:0] last,
                                                 input logic uns);
        case (last)
            2'd0:    return {{(DATA_W-8){~uns & v[7]}}, v[7:0]};
            2'd1:    return {{(DATA_W-16){~uns & v[15]}}, v[15:0]};
            default: return v;
        endcase
    endfunction

    // Request decode: size, alignment and range check (end address computed one bit wider)
    always_comb begin
        case (req_size)
            2'b00:   req_last = 2'd0;
            2'b01:   req_last = 2'd1;
            default: req_last = 2'd3;
        endcase
        req_end = {1'b0, req_addr} + (ADDR_W+1)'(req_last);
        req_err = (req_size == 2'b11)
                | ((req_size == 2'b01) & req_addr[0])
                | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00))
                | (|req_end[ADDR_W:MEM_AW]);
        cnt_d   = cnt_q + 2'd1;
        acc_d   = {acc_q[DATA_W-9:0], mem_rdata};
    end

    // Sequencer FSM; memory-side outputs are registered one cycle ahead of use
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            uns_q        <= 1'b0;
            last_q       <= 2'd0;
            cnt_q        <= 2'd0;
            addr_q       <= '0;
            wdata_q      <= '0;
            acc_q        <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= '0;
                    if (req_valid) begin
                        we_q    <= req_we;
                        uns_q   <= req_unsigned;
                        last_q  <= req_last;
                        addr_q  <= req_addr[MEM_AW-1:0];
                        wdata_q <= req_wdata;
                        cnt_q   <= 2'd0;
                        acc_q   <= '0;
                        if (req_err) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                        end else begin
                            state_q     <= ACCESS;
                            mem_we_q    <= req_we;
                            mem_addr_q  <= req_addr[MEM_AW-1:0];
                            mem_wdata_q <= req_we ? byte_sel(req_wdata, req_last) : 8'h00;
                        end
                    end
                end
                ACCESS: begin
                    if (!we_q) acc_q <= acc_d;
                    if (cnt_q == last_q) begin
                        state_q      <= RESP;
                        mem_we_q     <= 1'b0;
                        mem_addr_q   <= '0;
                        mem_wdata_q  <= '0;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= we_q ? '0 : extend(acc_d, last_q, uns_q);
                    end else begin
                        cnt_q       <= cnt_d;
                        mem_addr_q  <= addr_q + MEM_AW'(cnt_d);
                        mem_wdata_q <= we_q ? byte_sel(wdata_q, last_q - cnt_d) : 8'h00;
                    end
                end
                RESP: begin
                    state_q      <= IDLE;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Ready and write strobe are gated by reset so nothing is accepted or written in a reset cycle
    assign req_ready  = (state_q == IDLE) & ~reset;
    assign busy       = (state_q != IDLE);
    assign mem_we     = mem_we_q & ~reset;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Self-checking bench: directed + random load/store traffic against a byte-array reference.
module tb_mem_access_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_err, busy, mem_we;
    logic [31:0] resp_rdata;
    logic [7:0]  mem_addr, mem_wdata, mem_rdata;

    int checks = 0, failures = 0;

    logic [7:0]  mem    [256];
    logic [7:0]  refmem [256];
    logic        pre_we = 1'b0;
    logic [7:0]  pre_addr = '0, pre_data = '0;

    always #5 clk = ~clk;

    mem_access_sequencer #(.ADDR_W(32), .DATA_W(32), .MEM_AW(8)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Byte memory: bench preload port takes priority over the DUT write strobe
    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit ref_err(input logic [1:0] sz, input logic [31:0] a);
        longint n = nbytes(sz);
        if (sz == 2'b11) return 1'b1;
        if ((a % n) != 0) return 1'b1;
        return (longint'(a) + n) > 256;
    endfunction

    function automatic logic [31:0] ref_load(input int a, input int n, input bit uns);
        longint v = 0;
        for (int i = 0; i < n; i++) v = v * 256 + longint'(refmem[a + i]);
        if (!uns && v >= (64'sd1 <<< (8 * n - 1))) v = v - (64'sd1 <<< (8 * n));
        return v[31:0];
    endfunction

    task automatic mem_compare(input string tag);
        int bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== refmem[i]) bad++;
        chk(tag, bad, 0);
    endtask

    // One request: waits for acceptance, then tracks every cycle to the response pulse
    task automatic xact(input bit we, input logic [1:0] sz, input bit uns, input logic [31:0] a,
                        input logic [31:0] wd, input bit hold, output logic [31:0] rd);
        bit          err = ref_err(sz, a);
        int          n = nbytes(sz);
        int          lat = err ? 1 : n + 1;
        int          wes = 0;
        bit          got = 0;
        logic [31:0] exp_rd;
        int          k;
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        k = 0;
        while (!req_ready && k < 20) begin @(negedge clk); k++; end
        if (!req_ready) chk("accept_timeout", 1, 0);
        chk("busy_idle", busy, 0);
        @(posedge clk);
        rd = '0;
        for (k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (!hold) req_valid = 1'b0;
            if (mem_we) wes++;
            if (k <= lat) begin
                chk("ready_low", req_ready, 0);
                chk("busy_high", busy, 1);
            end
            if (!err && k <= n) chk("mem_addr", mem_addr, a[7:0] + 8'(k - 1));
            if (we && !err && k <= n) chk("mem_wdata", mem_wdata, (wd >> (8 * (n - k))) & 32'hFF);
            if (resp_valid) begin
                got = 1;
                rd = resp_rdata;
                chk("latency", k, lat);
                chk("resp_err", resp_err, err);
                chk("mem_we_resp", mem_we, 0);
                break;
            end
        end
        if (!got) chk("resp_timeout", 1, 0);
        chk("we_count", wes, (we && !err) ? n : 0);
        exp_rd = (we || err) ? 32'h0 : ref_load(int'(a), n, uns);
        chk("resp_rdata", rd, exp_rd);
        if (we && !err)
            for (int i = 0; i < n; i++) refmem[a + i] = 8'((wd >> (8 * (n - 1 - i))) & 32'hFF);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] ra;
        logic [1:0]  rs;
        // Preload memory with random bytes while reset is held
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            pre_we = 1'b1; pre_addr = 8'(i);
            case (i)
                16: pre_data = 8'h80;
                17: pre_data = 8'h12;
                18: pre_data = 8'h34;
                19: pre_data = 8'h56;
                default: pre_data = 8'($urandom);
            endcase
            refmem[i] = pre_data;
        end
        @(negedge clk);
        pre_we = 1'b0;
        chk("rst_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_rdata", resp_rdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        mem_compare("preload");
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", req_ready, 1);

        // Directed loads
        xact(0, 2'b10, 0, 32'h10, 0, 0, rd); chk("ld_word", rd, 32'h80123456);
        xact(0, 2'b00, 0, 32'h10, 0, 0, rd); chk("ld_byte_s", rd, 32'hFFFFFF80);
        xact(0, 2'b00, 1, 32'h10, 0, 0, rd); chk("ld_byte_u", rd, 32'h00000080);
        xact(0, 2'b01, 0, 32'h12, 0, 0, rd); chk("ld_half_s", rd, 32'h00003456);
        xact(0, 2'b01, 0, 32'h10, 0, 0, rd); chk("ld_half_neg", rd, 32'hFFFF8012);

        // Directed stores
        xact(1, 2'b10, 0, 32'h20, 32'hDEADBEEF, 0, rd);
        xact(1, 2'b01, 0, 32'h30, 32'h1234ABCD, 0, rd);
        @(negedge clk);
        chk("st_w0", mem[8'h20], 8'hDE); chk("st_w3", mem[8'h23], 8'hEF);
        chk("st_h0", mem[8'h30], 8'hAB); chk("st_h1", mem[8'h31], 8'hCD);

        // Errors: misaligned word/half, reserved size, out of range, huge address
        xact(0, 2'b10, 0, 32'h11, 0, 0, rd);
        xact(0, 2'b01, 0, 32'h13, 0, 0, rd);
        xact(0, 2'b11, 0, 32'h10, 0, 0, rd);
        xact(0, 2'b10, 0, 32'hFC, 0, 0, rd); chk("ld_word_top", rd, ref_load(252, 4, 0));
        xact(0, 2'b10, 0, 32'hFE, 0, 0, rd);
        xact(1, 2'b00, 0, 32'h100, 32'h55, 0, rd);
        xact(0, 2'b00, 1, 32'hFF, 0, 0, rd);
        mem_compare("after_errors");

        // Reset during the third access cycle of a word store at 0x40
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h40; req_wdata = 32'hA1B2C3D4;
        @(posedge clk);
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk);
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        chk("abort_mem_we", mem_we, 0);
        chk("abort_ready", req_ready, 0);
        chk("abort_resp", resp_valid, 0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("abort_ready_after", req_ready, 1);
        chk("abort_busy_after", busy, 0);
        for (int i = 0; i < 3; i++) begin
            chk("abort_no_resp", resp_valid, 0);
            @(negedge clk);
        end
        refmem[8'h40] = 8'hA1; refmem[8'h41] = 8'hB2;
        mem_compare("abort_mem");

        // Two queued loads with req_valid held high throughout
        xact(0, 2'b10, 0, 32'h20, 0, 1, rd); chk("q1", rd, 32'hDEADBEEF);
        xact(0, 2'b01, 1, 32'h22, 0, 0, rd); chk("q2", rd, 32'h0000BEEF);

        // Random traffic
        for (int t = 0; t < 60; t++) begin
            rs = 2'($urandom_range(0, 3));
            ra = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) ra = ra & ~32'(nbytes(rs) - 1);
            xact(1'($urandom), rs, 1'($urandom), ra, $urandom, 1'($urandom), rd);
        end
        req_valid = 1'b0;
        @(negedge clk);
        mem_compare("final_mem");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
